// File: rtl/mult_div_unit_if.sv
// Request/result bundle between a requester and the multi-cycle multiply/divide unit.
interface mult_div_unit_if;
    logic        start;
    logic        op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic        busy;
    logic        done;
    logic        div0;

    modport master (
        output start, op, in_a, in_b,
        input  out_hi, out_lo, busy, done, div0
    );

    modport slave (
        input  start, op, in_a, in_b,
        output out_hi, out_lo, busy, done, div0
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes)
// producing HI/LO results; 32 iteration cycles per operation.
module mult_div_unit (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [31:0] acc_hi, acc_lo, opnd;
    logic        acc_q1, neg_q, neg_r;
    logic [31:0] hi_q, lo_q;
    logic        div0_q;

    logic        last;
    logic [32:0] booth_sum;
    logic [31:0] mult_hi_nx, mult_lo_nx;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_hi_nx, div_lo_nx, quot, rem;
    logic [31:0] abs_a, abs_b;

    assign last  = (cnt == 5'd31);
    assign abs_a = bus.in_a[31] ? -bus.in_a : bus.in_a;
    assign abs_b = bus.in_b[31] ? -bus.in_b : bus.in_b;

    // Booth step: the add/subtract is done 33 bits wide so M = -2^31 cannot overflow,
    // and the arithmetic right shift folds the extra bit back into the 65-bit register.
    always_comb begin
        booth_sum = {acc_hi[31], acc_hi};
        case ({acc_lo[0], acc_q1})
            2'b01:   booth_sum = {acc_hi[31], acc_hi} + {opnd[31], opnd};
            2'b10:   booth_sum = {acc_hi[31], acc_hi} - {opnd[31], opnd};
            default: booth_sum = {acc_hi[31], acc_hi};
        endcase
        mult_hi_nx = booth_sum[32:1];
        mult_lo_nx = {booth_sum[0], acc_lo[31:1]};
    end

    // Restoring step: remainder stays below the divisor, so 32 bits hold it after the subtract.
    always_comb begin
        div_shift = {acc_hi, acc_lo[31]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_hi_nx = div_ge ? (div_shift[31:0] - opnd) : div_shift[31:0];
        div_lo_nx = {acc_lo[30:0], div_ge};
        quot      = neg_q ? -div_lo_nx : div_lo_nx;
        rem       = neg_r ? -div_hi_nx : div_hi_nx;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.op)               state_next = MULT;
                    else if (bus.in_b == '0)   state_next = DONE;
                    else                       state_next = DIV;
                end
            end
            MULT:    if (last) state_next = DONE;
            DIV:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            acc_q1 <= 1'b0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            div0_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= '0;
                        div0_q <= 1'b0;
                        acc_hi <= '0;
                        acc_q1 <= 1'b0;
                        if (!bus.op) begin
                            opnd   <= bus.in_a;
                            acc_lo <= bus.in_b;
                        end else if (bus.in_b == '0) begin
                            div0_q <= 1'b1;
                        end else begin
                            opnd   <= abs_b;
                            acc_lo <= abs_a;
                            neg_q  <= bus.in_a[31] ^ bus.in_b[31];
                            neg_r  <= bus.in_a[31];
                        end
                    end
                end
                MULT: begin
                    acc_hi <= mult_hi_nx;
                    acc_lo <= mult_lo_nx;
                    acc_q1 <= acc_lo[0];
                    cnt    <= cnt + 5'd1;
                    if (last) begin
                        hi_q <= mult_hi_nx;
                        lo_q <= mult_lo_nx;
                    end
                end
                DIV: begin
                    acc_hi <= div_hi_nx;
                    acc_lo <= div_lo_nx;
                    cnt    <= cnt + 5'd1;
                    if (last) begin
                        hi_q <= rem;
                        lo_q <= quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_hi = hi_q;
    assign bus.out_lo = lo_q;
    assign bus.div0   = div0_q;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  one-cycle request to begin an operation, honoured only in IDLE.
REQ-005 op  input  1  0 = signed multiply (MULT), 1 = signed divide (DIV), sampled with start.
REQ-006 in_a  input  32  multiplicand/dividend (rs), sampled with start.
REQ-007 in_b  input  32  multiplier/divisor (rt), sampled with start.
REQ-008 out_hi  output  32  HI register, feeding the writeback mux hi input.
REQ-009 out_lo  output  32  LO register, feeding the writeback mux lo input.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when an operation completes.
REQ-012 div0  output  1  sticky divide-by-zero flag, cleared on the next accepted start.

Function
REQ-013 The state machine SHALL have the states IDLE, MULT, DIV and DONE.
REQ-014 IDLE transitions: start=1 with op=0 goes to MULT; start=1 with op=1 and in_b!=0 goes to DIV; start=1 with op=1 and in_b==0 goes to DONE with div0 set.
REQ-015 Operands SHALL be captured into internal registers at the start edge, so that input changes afterwards have no effect.
REQ-016 MULT SHALL run exactly 32 iteration cycles using radix-2 Booth on a 65-bit accumulator, then go to DONE.
REQ-017 DIV SHALL run exactly 32 iteration cycles of restoring division on operand magnitudes, then go to DONE.
REQ-018 DIV sign rules: quotient is negated when in_a[31]^in_b[31]=1; remainder takes the sign of in_a.
REQ-019 On the DONE-entry edge, MULT SHALL write out_hi = product[63:32] and out_lo = product[31:0].
REQ-020 On the DONE-entry edge, DIV SHALL write out_lo = quotient and out_hi = remainder.
REQ-021 When div0 is set, out_hi and out_lo SHALL keep their previous values.
REQ-022 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE unconditionally.
REQ-023 Latency: start is sampled at edge N; for MULT/DIV, done is high in the cycle after edge N+33; for divide-by-zero, done is high in the cycle after edge N+1.
REQ-024 A start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-025 out_hi and out_lo SHALL change only on the DONE-entry edge or on reset; they hold stable in every other cycle, including mid-operation.
REQ-026 Division of 0x80000000 by 0xFFFFFFFF SHALL give out_lo=0x80000000 and out_hi=0x00000000, with no flag raised.
REQ-027 All arithmetic SHALL be two's complement, and intermediate widths SHALL prevent loss of the carry or sign bit.

Reset
REQ-028 When reset=1, the next state SHALL be IDLE and out_hi, out_lo, busy, done, div0 and all iteration counters and accumulators SHALL be cleared to 0.
REQ-029 Reset SHALL override start in the same cycle.
REQ-030 Reset during MULT, DIV or DONE SHALL abort the operation, with no done pulse and no HI/LO update.
REQ-031 After reset deassertion, a start on the first sampled edge SHALL be accepted normally.

Verification
REQ-032 MULT with in_a=7 and in_b=0xFFFFFFFD (-3) SHALL give out_hi=0xFFFFFFFF and out_lo=0xFFFFFFEB, with the done pulse exactly 33 edges after start.
REQ-033 MULT with in_a=0x80000000 and in_b=0x80000000 SHALL give out_hi=0x40000000 and out_lo=0x00000000.
REQ-034 DIV with in_a=0xFFFFFFF9 (-7) and in_b=2 SHALL give out_lo=0xFFFFFFFD and out_hi=0xFFFFFFFF; DIV 100/7 SHALL give out_lo=14 and out_hi=2.
REQ-035 DIV with in_b=0, after a prior result hi=0x11 and lo=0x22, SHALL give done 1 edge after start, div0=1 and out_hi/out_lo unchanged; a following accepted start SHALL clear div0.
REQ-036 A MULT started, then reset asserted at iteration 10, SHALL give busy=0 and out_hi=out_lo=0 with no done pulse; a second start issued at iteration 5 of a running op SHALL be ignored, with the result matching the first op only.
